sys_write_arbiter: RTL and testbench
====================================

Name: sys_write_arbiter

Overview:
- Shares the single system write port (sys_wr / sys_waddr / sys_wdata) between NREQ requesters, e.g. the UART debug interface and a CPU/DMA master.
- Round-robin, one write in flight at a time, with a valid/ack handshake to each requester and a ready back-pressure input from the write target.
- Sits between the write masters and the memory/peripheral write bus.
- Also provides a saturating contention counter for debug.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 16, address width.
- DW, 16, data width.
- IW, $clog2(NREQ), grant index width (derived, not overridden).

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester write request; held with addr/data until acked.
- req_addr  in  NREQ*AW  packed addresses; requester i uses [i*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester i uses [i*DW +: DW].
- req_ack  out  NREQ  one-cycle pulse: requester's write accepted by target.
- sys_wr  out  1  write strobe to target.
- sys_waddr  out  AW  write address.
- sys_wdata  out  DW  write data.
- sys_ready  in  1  target accepts the write this cycle when sys_wr=1.
- grant_id  out  IW  index of current/last granted requester.
- contention_cnt  out  16  count of grants made while ≥2 requests were pending.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous, active-low.
- Reset values: state=IDLE, sys_wr=0, sys_waddr=0, sys_wdata=0, req_ack=0, grant_id=NREQ-1 (so requester 0 wins first), contention_cnt=0.
- States: IDLE, ISSUE.
- IDLE:
  - If any req_valid=1, select the first valid index scanning upward from grant_id+1 modulo NREQ.
  - Register its addr/data into sys_waddr/sys_wdata, set grant_id, go to ISSUE.
  - If no request, hold; sys_wr=0.
- ISSUE:
  - sys_wr=1 (registered; driven from state).
  - If sys_ready=1: req_ack[grant_id]=1 combinationally in that same cycle, and go to IDLE at the next edge.
  - Otherwise stay in ISSUE with addr/data/grant_id frozen.
- req_ack is combinational: (state==ISSUE) & sys_ready, decoded onto bit grant_id. All other ack bits are 0. At most one bit is high in any cycle.
- Requester rules:
  - Hold req_valid/addr/data stable until the ack cycle.
  - Deassert valid, or present the next write, at the edge following ack.
  - Requests are never withdrawn unacked. A valid drop while granted is ignored; the latched write still completes.
- Throughput: at most one write per 2 cycles, so 1 write every 2 cycles with sys_ready tied 1.
- Latency: with sys_ready=1, req_valid high at edge N gives sys_wr high in cycle N+1 and ack in cycle N+1.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants. grant_id persists across IDLE so rotation continues.
- Single requester: it is re-granted back-to-back every 2 cycles.
- contention_cnt: increments on the IDLE→ISSUE transition when popcount(req_valid) ≥ 2. Saturates at 16'hFFFF with no wrap.
- sys_wdata/sys_waddr retain the last issued values in IDLE; only sys_wr qualifies them.
- Reset mid-ISSUE: sys_wr drops asynchronously, no ack is generated, the pending write is lost, and requesters must re-present after reset.
- Requests with valid=1 in the reset-release cycle are handled normally starting in the first IDLE cycle.

Test Plan:
- Reset, then req_valid=2'b01 with addr=16'h0010 and data=16'hBEEF, sys_ready=1 → sys_wr=1 with sys_waddr=0010/sys_wdata=BEEF in the cycle after, req_ack=2'b01 in the same cycle, contention_cnt=0.
- NREQ=2, both valid continuously (r0 addrs 0,1,2…; r1 addrs 100,101…), sys_ready=1 → grants alternate 0,1,0,1. Issued addresses are 0,100,1,101. contention_cnt increments per grant.
- sys_ready held 0 for 5 cycles during ISSUE → sys_wr stays 1, addr/data/grant_id stable, no ack. Ack occurs in the cycle sys_ready rises.
- NREQ=4, requesters 1 and 3 valid, grant_id=1 → requester 3 granted next, then 1. Requester 0 raised later is served before 1 is re-granted if 1's turn has passed.
- Assert sys_rst_n=0 mid-ISSUE → sys_wr=0 immediately, req_ack=0, grant_id=NREQ-1, contention_cnt=0. After release, requester 0 wins first.
- Force contention_cnt near 16'hFFFE via repeated dual requests → counter reaches FFFF and holds.

Source files
------------

// File: rtl/sys_write_arbiter.sv
// sys_write_arbiter: round-robin sharing of the single system write port
// between NREQ requesters. One write is in flight at a time. Each requester
// sees a valid/ack handshake, and the target can hold off with sys_ready.
// A saturating counter records how many grants were made under contention.
module sys_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    output logic               sys_wr,
    output logic [AW-1:0]      sys_waddr,
    output logic [DW-1:0]      sys_wdata,
    input  logic               sys_ready,
    output logic [IW-1:0]      grant_id,
    output logic [15:0]        contention_cnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]    state;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [3:0]    req_pop;

    // Round-robin pick: first valid requester scanning upward from the one
    // after the last grant. The last grant itself is examined last.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_t;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        idx_t     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(grant_id) + k) % NREQ;
            idx_t = IW'(idx);
            if (!sel_found && req_valid[idx_t]) begin
                sel_found = 1'b1;
                sel_idx   = idx_t;
            end
        end
    end

    // Count the pending requests so contention can be detected at grant time.
    always_comb begin
        req_pop = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            req_pop = req_pop + 4'(req_valid[i +: 1]);
        end
    end

    // State, latched write, grant index and contention counter. Address and
    // data are captured at grant so that requester changes during ISSUE are
    // ignored.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            sys_waddr      <= '0;
            sys_wdata      <= '0;
            grant_id       <= IW'(NREQ - 1);
            contention_cnt <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        sys_waddr <= req_addr[sel_idx*AW +: AW];
                        sys_wdata <= req_data[sel_idx*DW +: DW];
                        grant_id  <= sel_idx;
                        state     <= ISSUE;
                        if (req_pop >= 4'd2 && contention_cnt != 16'hFFFF)
                            contention_cnt <= contention_cnt + 16'd1;
                    end
                end
                ISSUE: begin
                    if (sys_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe comes straight from the state register, so it drops
    // as soon as reset asserts.
    assign sys_wr = (state == ISSUE);

    // The ack goes to the granted requester in the cycle the target accepts.
    always_comb begin
        req_ack = '0;
        if (state == ISSUE && sys_ready) req_ack[grant_id] = 1'b1;
    end

endmodule

// File: tb/tb_sys_write_arbiter.sv
// Scoreboard bench for sys_write_arbiter. It uses a 2-requester and a
// 4-requester instance. Driver processes present queued writes and advance
// on ack. The monitors pop the expected writes and compare at each accepted
// write.
module tb_sys_write_arbiter;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   acks4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb2[$];
    exp_t        sb4[$];
    logic [31:0] st2[2][$];
    logic [31:0] st4[4][$];
    int          ack_cyc2[$];

    // 2-requester instance
    logic [1:0]  v2, ack2;
    logic [31:0] a2, d2;
    logic        wr2, rdy2;
    logic [15:0] waddr2, wdata2, cnt2;
    logic [0:0]  gid2;

    sys_write_arbiter #(.NREQ(2), .AW(16), .DW(16)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_valid(v2), .req_addr(a2), .req_data(d2), .req_ack(ack2),
        .sys_wr(wr2), .sys_waddr(waddr2), .sys_wdata(wdata2),
        .sys_ready(rdy2), .grant_id(gid2), .contention_cnt(cnt2)
    );

    // 4-requester instance
    logic [3:0]  v4, ack4;
    logic [63:0] a4, d4;
    logic        wr4, rdy4;
    logic [15:0] waddr4, wdata4, cnt4;
    logic [1:0]  gid4;

    sys_write_arbiter #(.NREQ(4), .AW(16), .DW(16)) dut4 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_valid(v4), .req_addr(a4), .req_data(d4), .req_ack(ack4),
        .sys_wr(wr4), .sys_waddr(waddr4), .sys_wdata(wdata4),
        .sys_ready(rdy4), .grant_id(gid4), .contention_cnt(cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic put2(input int r, input logic [15:0] a, input logic [15:0] d);
        st2[r].push_back({a, d});
    endtask

    task automatic put4(input int r, input logic [15:0] a, input logic [15:0] d);
        st4[r].push_back({a, d});
    endtask

    task automatic exp2(input logic [2:0] id, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] c);
        exp_t e;
        e.id = id; e.addr = a; e.data = d; e.cnt = c;
        sb2.push_back(e);
    endtask

    task automatic exp4(input logic [2:0] id, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] c);
        exp_t e;
        e.id = id; e.addr = a; e.data = d; e.cnt = c;
        sb4.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a scoreboard to drain, then let the DUT settle in IDLE.
    task automatic wait_sb(input int which, input int budget);
        int n = 0;
        while (((which == 2) ? sb2.size() : sb4.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk((which == 2) ? "sb2_drain" : "sb4_drain",
            32'((which == 2) ? sb2.size() : sb4.size()), 32'd0);
        tick();
    endtask

    // Drivers: present the head of each requester queue and pop it on ack.
    initial begin
        v2 = '0; a2 = '0; d2 = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ack2[i +: 1] == 1'b1 && st2[i].size() > 0) void'(st2[i].pop_front());
                if (st2[i].size() > 0) begin
                    v2[i +: 1]     = 1'b1;
                    a2[i*16 +: 16] = st2[i][0][31:16];
                    d2[i*16 +: 16] = st2[i][0][15:0];
                end else begin
                    v2[i +: 1] = 1'b0;
                end
            end
        end
    end

    initial begin
        v4 = '0; a4 = '0; d4 = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ack4[i +: 1] == 1'b1 && st4[i].size() > 0) void'(st4[i].pop_front());
                if (st4[i].size() > 0) begin
                    v4[i +: 1]     = 1'b1;
                    a4[i*16 +: 16] = st4[i][0][31:16];
                    d4[i*16 +: 16] = st4[i][0][15:0];
                end else begin
                    v4[i +: 1] = 1'b0;
                end
            end
        end
    end

    // Monitors: every accepted write is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((wr2 && rdy2) || ack2 != 2'b00) begin
                if (sb2.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL w2_unexpected: actual addr %h ack %b required no write", waddr2, ack2);
                end else begin
                    e = sb2.pop_front();
                    chk("w2_ack",  32'(ack2),   32'(1) << e.id);
                    chk("w2_gid",  32'(gid2),   32'(e.id));
                    chk("w2_addr", 32'(waddr2), 32'(e.addr));
                    chk("w2_data", 32'(wdata2), 32'(e.data));
                    chk("w2_cnt",  32'(cnt2),   32'(e.cnt));
                    ack_cyc2.push_back(cyc);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((wr4 && rdy4) || ack4 != 4'b0000) begin
                if (sb4.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL w4_unexpected: actual addr %h ack %b required no write", waddr4, ack4);
                end else begin
                    e = sb4.pop_front();
                    chk("w4_ack",  32'(ack4),   32'(1) << e.id);
                    chk("w4_gid",  32'(gid4),   32'(e.id));
                    chk("w4_addr", 32'(waddr4), 32'(e.addr));
                    chk("w4_data", 32'(wdata4), 32'(e.data));
                    chk("w4_cnt",  32'(cnt4),   32'(e.cnt));
                    acks4++;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; rdy2 = 1'b1; rdy4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr",    32'(wr2),    32'd0);
        chk("rst_waddr", 32'(waddr2), 32'd0);
        chk("rst_wdata", 32'(wdata2), 32'd0);
        chk("rst_ack",   32'(ack2),   32'd0);
        chk("rst_gid",   32'(gid2),   32'd1);
        chk("rst_cnt",   32'(cnt2),   32'd0);
        chk("rst_gid4",  32'(gid4),   32'd3);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0, one-cycle latency
        put2(0, 16'h0010, 16'hBEEF);
        exp2(3'd0, 16'h0010, 16'hBEEF, 16'h0000);
        tick();
        chk("t1_wr",    32'(wr2),    32'd1);
        chk("t1_waddr", 32'(waddr2), 32'h0010);
        chk("t1_wdata", 32'(wdata2), 32'hBEEF);
        chk("t1_ack",   32'(ack2),   32'b01);
        chk("t1_cnt",   32'(cnt2),   32'd0);
        wait_sb(2, 10);

        // Lone requester 1 is re-granted every two cycles
        ack_cyc2.delete();
        put2(1, 16'h0200, 16'hA200); put2(1, 16'h0201, 16'hA201); put2(1, 16'h0202, 16'hA202);
        exp2(3'd1, 16'h0200, 16'hA200, 16'h0000);
        exp2(3'd1, 16'h0201, 16'hA201, 16'h0000);
        exp2(3'd1, 16'h0202, 16'hA202, 16'h0000);
        wait_sb(2, 20);
        chk("t1b_nacks", 32'(ack_cyc2.size()), 32'd3);
        if (ack_cyc2.size() == 3) begin
            chk("t1b_gap0", 32'(ack_cyc2[1] - ack_cyc2[0]), 32'd2);
            chk("t1b_gap1", 32'(ack_cyc2[2] - ack_cyc2[1]), 32'd2);
        end

        // Both requesters busy: strict alternation, contention counted
        put2(0, 16'h0000, 16'h5A00); put2(0, 16'h0001, 16'h5A01);
        put2(1, 16'h0100, 16'h6100); put2(1, 16'h0101, 16'h6101);
        exp2(3'd0, 16'h0000, 16'h5A00, 16'd1);
        exp2(3'd1, 16'h0100, 16'h6100, 16'd2);
        exp2(3'd0, 16'h0001, 16'h5A01, 16'd3);
        exp2(3'd1, 16'h0101, 16'h6101, 16'd3);
        wait_sb(2, 30);

        // Target stall: write held frozen, ack only when ready rises
        rdy2 = 1'b0;
        put2(0, 16'h0030, 16'hC0DE);
        exp2(3'd0, 16'h0030, 16'hC0DE, 16'd3);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_wr",   32'(wr2),             32'd1);
            chk("t3_hold", {waddr2, wdata2},     32'h0030C0DE);
            chk("t3_gid",  32'(gid2),            32'd0);
            chk("t3_ack",  32'(ack2),            32'd0);
            tick();
        end
        rdy2 = 1'b1;
        #1;
        chk("t3_ack_rise", 32'(ack2), 32'b01);
        wait_sb(2, 10);

        // Counter saturation from just below the top
        force dut2.contention_cnt = 16'hFFFD;
        tick();
        release dut2.contention_cnt;
        tick();
        chk("t4_preset", 32'(cnt2), 32'h0000FFFD);
        put2(0, 16'h0040, 16'h7040); put2(0, 16'h0041, 16'h7041); put2(0, 16'h0042, 16'h7042);
        put2(1, 16'h0140, 16'h8140); put2(1, 16'h0141, 16'h8141);
        exp2(3'd1, 16'h0140, 16'h8140, 16'hFFFE);
        exp2(3'd0, 16'h0040, 16'h7040, 16'hFFFF);
        exp2(3'd1, 16'h0141, 16'h8141, 16'hFFFF);
        exp2(3'd0, 16'h0041, 16'h7041, 16'hFFFF);
        exp2(3'd0, 16'h0042, 16'h7042, 16'hFFFF);
        wait_sb(2, 40);
        chk("t4_hold", 32'(cnt2), 32'h0000FFFF);

        // Four requesters: rotation order, late requester 0 cuts in ahead of 1
        put4(1, 16'h0101, 16'h0B01); put4(1, 16'h0102, 16'h0B02); put4(1, 16'h0103, 16'h0B03);
        put4(3, 16'h0301, 16'h0D01); put4(3, 16'h0302, 16'h0D02);
        exp4(3'd1, 16'h0101, 16'h0B01, 16'd1);
        exp4(3'd3, 16'h0301, 16'h0D01, 16'd2);
        exp4(3'd1, 16'h0102, 16'h0B02, 16'd3);
        n = 0;
        while (acks4 < 3 && n < 30) begin
            tick();
            n++;
        end
        chk("t6_three_acks", 32'(acks4), 32'd3);
        chk("t6_gid", 32'(gid4), 32'd1);
        put4(0, 16'h0001, 16'h0A01);
        exp4(3'd3, 16'h0302, 16'h0D02, 16'd4);
        exp4(3'd0, 16'h0001, 16'h0A01, 16'd5);
        exp4(3'd1, 16'h0103, 16'h0B03, 16'd5);
        wait_sb(4, 30);

        // Reset in the middle of a stalled write: write lost, state restored
        rdy2 = 1'b0;
        put2(0, 16'h0050, 16'hDEAD);
        tick();
        tick();
        chk("t5_in_issue", 32'(wr2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr",    32'(wr2),    32'd0);
        chk("t5_ack",   32'(ack2),   32'd0);
        chk("t5_gid",   32'(gid2),   32'd1);
        chk("t5_cnt",   32'(cnt2),   32'd0);
        chk("t5_waddr", 32'(waddr2), 32'd0);
        st2[0].delete();
        rdy2 = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        put2(0, 16'h0060, 16'h1234);
        put2(1, 16'h0160, 16'h5678);
        exp2(3'd0, 16'h0060, 16'h1234, 16'd1);
        exp2(3'd1, 16'h0160, 16'h5678, 16'd1);
        wait_sb(2, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
